// File: rtl/tone_mixer_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : tone_mixer_pkg
//  Purpose  : Shared mode encodings and the sample saturation helper for the
//             tone generator / mixer datapath.
//  Revision : 1.0  initial release
// ============================================================================
package tone_mixer_pkg;

    // Waveform selection per channel
    localparam logic [1:0] MODE_SQUARE = 2'b00;
    localparam logic [1:0] MODE_PULSE  = 2'b01;
    localparam logic [1:0] MODE_INV    = 2'b10;
    localparam logic [1:0] MODE_OFF    = 2'b11;

    // Working width of the saturation helper; callers zero-extend into it
    localparam int SAT_W = 64;

    // Clamp an unsigned sum to the largest value representable in out_w bits
    function automatic logic [SAT_W-1:0] saturate(input logic [SAT_W-1:0] sum,
                                                  input int               out_w);
        logic [SAT_W-1:0] max_val;
        max_val = (64'd1 << out_w) - 64'd1;
        return (sum > max_val) ? max_val : sum;
    endfunction

endpackage
`default_nettype wire

// File: rtl/tone_mixer_if.sv
`default_nettype none
// ============================================================================
//  Module   : tone_mixer_if
//  Purpose  : Configuration bus plus the valid/ready sample stream of the
//             tone mixer. The master is the controller / downstream side, the
//             slave is the mixer itself.
//  Revision : 1.0  initial release
// ============================================================================
interface tone_mixer_if #(
    parameter int CHANNELS = 4,
    parameter int PERIOD_W = 21,
    parameter int VOL_W    = 16,
    parameter int OUT_W    = 16,
    parameter int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
);
    logic                cfg_we;
    logic [CH_W-1:0]     cfg_ch;
    logic [PERIOD_W-1:0] cfg_half_period;
    logic [VOL_W-1:0]    cfg_volume;
    logic [1:0]          cfg_mode;
    logic [OUT_W-1:0]    sample;
    logic                sample_valid;
    logic                sample_ready;

    modport master (
        output cfg_we, cfg_ch, cfg_half_period, cfg_volume, cfg_mode, sample_ready,
        input  sample, sample_valid
    );

    modport slave (
        input  cfg_we, cfg_ch, cfg_half_period, cfg_volume, cfg_mode, sample_ready,
        output sample, sample_valid
    );
endinterface
`default_nettype wire

// File: rtl/tone_channel.sv
`default_nettype none
// ============================================================================
//  Module   : tone_channel
//  Purpose  : One tone voice: half-period counter, level flop, config
//             registers and the waveform/volume output mux.
//  Revision : 1.0  initial release
// ============================================================================
module tone_channel
    import tone_mixer_pkg::*;
#(
    parameter int PERIOD_W = 21,
    parameter int VOL_W    = 16
) (
    input  wire logic                clk,
    input  wire logic                rst,
    input  wire logic                i_enable,
    input  wire logic                i_cfg_wr,
    input  wire logic [PERIOD_W-1:0] i_cfg_half_period,
    input  wire logic [VOL_W-1:0]    i_cfg_volume,
    input  wire logic [1:0]          i_cfg_mode,
    output logic      [VOL_W-1:0]    o_ch_out
);

    logic [PERIOD_W-1:0] half_period_q, half_period_d;
    logic [VOL_W-1:0]    volume_q,      volume_d;
    logic [1:0]          mode_q,        mode_d;
    logic [PERIOD_W-1:0] counter_q,     counter_d;
    logic                level_q,       level_d;
    // Registered enable so that enable changes reach the output on the next edge
    logic                en_q,          en_d;

    logic                w_pulse_win;
    logic                w_on;

    // Next-state: a config write restarts the phase and wins over counting
    always_comb begin
        half_period_d = half_period_q;
        volume_d      = volume_q;
        mode_d        = mode_q;
        counter_d     = counter_q;
        level_d       = level_q;
        en_d          = i_enable;
        if (i_cfg_wr) begin
            half_period_d = i_cfg_half_period;
            volume_d      = i_cfg_volume;
            mode_d        = i_cfg_mode;
            counter_d     = '0;
            level_d       = 1'b0;
        end else if (!i_enable) begin
            counter_d = '0;
            level_d   = 1'b0;
        end else if (counter_q >= half_period_q) begin
            counter_d = '0;
            level_d   = ~level_q;
        end else begin
            counter_d = counter_q + 1'b1;
        end
    end

    // Channel state registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            half_period_q <= '0;
            volume_q      <= '0;
            mode_q        <= MODE_SQUARE;
            counter_q     <= '0;
            level_q       <= 1'b0;
            en_q          <= 1'b0;
        end else begin
            half_period_q <= half_period_d;
            volume_q      <= volume_d;
            mode_q        <= mode_d;
            counter_q     <= counter_d;
            level_q       <= level_d;
            en_q          <= en_d;
        end
    end

    // Waveform select from registered state; pulse is the first half of the high phase
    always_comb begin
        w_pulse_win = (counter_q <= (half_period_q >> 1));
        case (mode_q)
            MODE_SQUARE: w_on = level_q;
            MODE_PULSE:  w_on = level_q && w_pulse_win;
            MODE_INV:    w_on = !level_q;
            default:     w_on = 1'b0;
        endcase
        o_ch_out = (en_q && w_on) ? volume_q : '0;
    end

endmodule
`default_nettype wire

// File: rtl/tone_mixer.sv
`default_nettype none
// ============================================================================
//  Module   : tone_mixer
//  Purpose  : CHANNELS tone voices summed with saturation into one sample,
//             latched on sample_tick and offered on a valid/ready stream with
//             sticky overrun detection.
//  Revision : 1.0  initial release
// ============================================================================
module tone_mixer
    import tone_mixer_pkg::*;
#(
    parameter int CHANNELS = 4,
    parameter int PERIOD_W = 21,
    parameter int VOL_W    = 16,
    parameter int OUT_W    = 16
) (
    input  wire logic                clk,
    input  wire logic                rst,
    input  wire logic [CHANNELS-1:0] enable,
    input  wire logic                sample_tick,
    output logic                     overrun,
    tone_mixer_if.slave              bus
);

    localparam int CH_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int SUM_W = VOL_W + $clog2(CHANNELS) + 1;

    logic [VOL_W-1:0] w_ch_out [CHANNELS];
    logic [SUM_W-1:0] w_sum;
    logic [OUT_W-1:0] w_sat;

    logic [OUT_W-1:0] sample_q,  sample_d;
    logic             valid_q,   valid_d;
    logic             overrun_q, overrun_d;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_channel
        // Equality against a real channel index also rejects out-of-range cfg_ch
        logic w_wr;
        assign w_wr = bus.cfg_we && (32'(bus.cfg_ch) == i);

        tone_channel #(
            .PERIOD_W (PERIOD_W),
            .VOL_W    (VOL_W)
        ) u_channel (
            .clk               (clk),
            .rst               (rst),
            .i_enable          (enable[i]),
            .i_cfg_wr          (w_wr),
            .i_cfg_half_period (bus.cfg_half_period),
            .i_cfg_volume      (bus.cfg_volume),
            .i_cfg_mode        (bus.cfg_mode),
            .o_ch_out          (w_ch_out[i])
        );
    end

    // Full-width sum of all voices, then clamp to the output range
    always_comb begin
        w_sum = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            w_sum = w_sum + SUM_W'(w_ch_out[i]);
        end
        w_sat = OUT_W'(saturate(SAT_W'(w_sum), OUT_W));
    end

    // Sample handshake: a tick always loads; overrun only if the old sample was not taken
    always_comb begin
        sample_d  = sample_q;
        valid_d   = valid_q;
        overrun_d = overrun_q;
        if (sample_tick) begin
            sample_d = w_sat;
            valid_d  = 1'b1;
            if (valid_q && !bus.sample_ready) begin
                overrun_d = 1'b1;
            end
        end else if (valid_q && bus.sample_ready) begin
            valid_d = 1'b0;
        end
    end

    // Output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sample_q  <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            sample_q  <= sample_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
        end
    end

    assign bus.sample       = sample_q;
    assign bus.sample_valid = valid_q;
    assign overrun          = overrun_q;

    // Unused when CHANNELS is a power of two, kept for clarity of the decode width
    localparam int c_ch_w_unused = CH_W;

endmodule
`default_nettype wire

// File: tb/tb_tone_mixer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_tone_mixer
//  Purpose  : Self-checking bench for tone_mixer: static mix vectors, a
//             closed-form scoreboard for running waveforms, handshake,
//             reset and out-of-range configuration sequences.
//  Revision : 1.0  initial release
// ============================================================================
module tb_tone_mixer;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] enable;
    logic       sample_tick;
    logic       overrun;

    logic [2:0] enable3;
    logic       tick3;
    logic       overrun3;

    always #5 clk = ~clk;

    tone_mixer_if #(.CHANNELS(4), .PERIOD_W(21), .VOL_W(16), .OUT_W(16)) bus ();
    tone_mixer_if #(.CHANNELS(3), .PERIOD_W(21), .VOL_W(16), .OUT_W(16)) bus3 ();

    tone_mixer #(.CHANNELS(4), .PERIOD_W(21), .VOL_W(16), .OUT_W(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .sample_tick (sample_tick),
        .overrun     (overrun),
        .bus         (bus)
    );

    tone_mixer #(.CHANNELS(3), .PERIOD_W(21), .VOL_W(16), .OUT_W(16)) dut3 (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable3),
        .sample_tick (tick3),
        .overrun     (overrun3),
        .bus         (bus3)
    );

    int errors = 0;
    int checks = 0;

    task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input int ch, input int hp, input logic [15:0] vol, input logic [1:0] mode);
        bus.cfg_we          = 1'b1;
        bus.cfg_ch          = 2'(ch);
        bus.cfg_half_period = 21'(hp);
        bus.cfg_volume      = vol;
        bus.cfg_mode        = mode;
        step();
        bus.cfg_we          = 1'b0;
    endtask

    // ------------------------------------------------------------------
    // Static mix vectors (long half period so every level stays 0)
    // ------------------------------------------------------------------
    typedef struct packed {
        logic [3:0][15:0] vol;
        logic [3:0][1:0]  mode;
        logic [3:0]       en;
        logic [15:0]      exp;
    } vec_t;

    vec_t vecs [9];

    function automatic vec_t mk(input logic [15:0] v0, input logic [15:0] v1,
                                input logic [15:0] v2, input logic [15:0] v3,
                                input logic [7:0] modes, input logic [3:0] en,
                                input logic [15:0] exp);
        vec_t v;
        v.vol[0] = v0;
        v.vol[1] = v1;
        v.vol[2] = v2;
        v.vol[3] = v3;
        v.mode   = modes;
        v.en     = en;
        v.exp    = exp;
        return v;
    endfunction

    // ------------------------------------------------------------------
    // Closed-form waveform model for one active channel
    // ------------------------------------------------------------------
    function automatic logic [15:0] exp_out(input bit en, input logic [1:0] mode, input int hp,
                                            input logic [15:0] vol, input int n);
        int c;
        bit lvl;
        bit on;
        c   = n % (hp + 1);
        lvl = ((n / (hp + 1)) % 2) == 1;
        case (mode)
            2'b00:   on = lvl;
            2'b01:   on = lvl && (c <= hp / 2);
            2'b10:   on = !lvl;
            default: on = 1'b0;
        endcase
        return (en && on) ? vol : 16'h0000;
    endfunction

    int          m_ch;
    bit          m_en;
    logic [1:0]  m_mode;
    int          m_hp;
    logic [15:0] m_vol;
    int          m_n;
    logic [1:0]  n_mode;
    int          n_hp;
    logic [15:0] n_vol;
    logic [15:0] sb [$];

    // One ticked clock: push the model's sample, apply stimulus, pop and compare
    task automatic sb_cycle(input bit do_wr, input bit en_next);
        sb.push_back(exp_out(m_en, m_mode, m_hp, m_vol, m_n));
        sample_tick         = 1'b1;
        enable              = 4'b0000;
        enable[m_ch]        = en_next;
        bus.cfg_we          = do_wr;
        bus.cfg_ch          = 2'(m_ch);
        bus.cfg_half_period = 21'(n_hp);
        bus.cfg_volume      = n_vol;
        bus.cfg_mode        = n_mode;
        step();
        sample_tick = 1'b0;
        bus.cfg_we  = 1'b0;
        if (do_wr) begin
            m_n    = 0;
            m_hp   = n_hp;
            m_vol  = n_vol;
            m_mode = n_mode;
        end else if (!en_next) begin
            m_n = 0;
        end else begin
            m_n++;
        end
        m_en = en_next;
        if (!bus.sample_valid || sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_valid: sample_valid=%b queued=%0d", bus.sample_valid, sb.size());
        end else begin
            check16("sb_sample", bus.sample, sb.pop_front());
        end
    endtask

    task automatic go_idle();
        enable = 4'b0000;
        step();
        step();
        m_en = 1'b0;
        m_n  = 0;
    endtask

    initial begin
        rst                  = 1'b1;
        enable               = 4'b0000;
        sample_tick          = 1'b0;
        bus.cfg_we           = 1'b0;
        bus.cfg_ch           = '0;
        bus.cfg_half_period  = '0;
        bus.cfg_volume       = '0;
        bus.cfg_mode         = 2'b00;
        bus.sample_ready     = 1'b1;
        enable3              = 3'b000;
        tick3                = 1'b0;
        bus3.cfg_we          = 1'b0;
        bus3.cfg_ch          = '0;
        bus3.cfg_half_period = '0;
        bus3.cfg_volume      = '0;
        bus3.cfg_mode        = 2'b00;
        bus3.sample_ready    = 1'b1;

        vecs[0] = mk(16'h6000, 16'h6000, 16'h6000, 16'h6000, 8'hAA, 4'hF, 16'hFFFF);
        vecs[1] = mk(16'h6000, 16'h6000, 16'h6000, 16'h6000, 8'hAA, 4'h3, 16'hC000);
        vecs[2] = mk(16'h6000, 16'h6000, 16'h6000, 16'h6000, 8'h0A, 4'hF, 16'hC000);
        vecs[3] = mk(16'h1000, 16'h2000, 16'h4000, 16'h8000, 8'hD2, 4'hF, 16'h1000);
        vecs[4] = mk(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 8'hAA, 4'hF, 16'hFFFF);
        vecs[5] = mk(16'h0001, 16'h0002, 16'h0004, 16'hFFF0, 8'hAA, 4'hF, 16'hFFF7);
        vecs[6] = mk(16'h8000, 16'h7FFF, 16'h0000, 16'h0000, 8'hAA, 4'h3, 16'hFFFF);
        vecs[7] = mk(16'h8000, 16'h8000, 16'h0000, 16'h0000, 8'hAA, 4'h3, 16'hFFFF);
        vecs[8] = mk(16'h0000, 16'h0000, 16'h0000, 16'h5555, 8'hAA, 4'h8, 16'h5555);

        // Reset state
        step();
        step();
        check16("reset_sample", bus.sample, 16'h0000);
        check1("reset_valid", bus.sample_valid, 1'b0);
        check1("reset_overrun", overrun, 1'b0);
        rst = 1'b0;
        step();

        // Static mixing and saturation
        for (int v = 0; v < 9; v++) begin
            enable = vecs[v].en;
            for (int c = 0; c < 4; c++) begin
                cfg_write(c, 1000, vecs[v].vol[c], vecs[v].mode[c]);
            end
            step();
            sample_tick = 1'b1;
            step();
            sample_tick = 1'b0;
            check16($sformatf("mix_vec%0d", v), bus.sample, vecs[v].exp);
        end

        // Square on ch0, mid-period restart, then disable while high
        go_idle();
        m_ch = 0; n_hp = 3; n_vol = 16'h1000; n_mode = 2'b00;
        sb_cycle(1'b1, 1'b1);
        repeat (13) sb_cycle(1'b0, 1'b1);
        sb_cycle(1'b1, 1'b1);
        repeat (5) sb_cycle(1'b0, 1'b1);
        repeat (4) sb_cycle(1'b0, 1'b0);

        // Pulse on ch1, then inverted square on the same settings
        go_idle();
        m_ch = 1; n_hp = 7; n_vol = 16'h0800; n_mode = 2'b01;
        sb_cycle(1'b1, 1'b1);
        repeat (33) sb_cycle(1'b0, 1'b1);
        n_mode = 2'b10;
        sb_cycle(1'b1, 1'b1);
        repeat (20) sb_cycle(1'b0, 1'b1);
        repeat (2) sb_cycle(1'b0, 1'b0);

        // Handshake: tick with ready in the same cycle is not an overrun
        enable = 4'b0001;
        cfg_write(0, 1000, 16'h1234, 2'b10);
        step();
        bus.sample_ready = 1'b1;
        sample_tick      = 1'b1;
        step();
        check1("hs_valid_set", bus.sample_valid, 1'b1);
        check16("hs_sample1", bus.sample, 16'h1234);
        step();
        sample_tick = 1'b0;
        check1("hs_tick_ready_valid", bus.sample_valid, 1'b1);
        check1("hs_tick_ready_no_overrun", overrun, 1'b0);
        step();
        check1("hs_drain", bus.sample_valid, 1'b0);

        // Two ticks five clocks apart with ready low
        bus.sample_ready = 1'b0;
        sample_tick      = 1'b1;
        step();
        sample_tick = 1'b0;
        check1("hs_first_no_overrun", overrun, 1'b0);
        cfg_write(0, 1000, 16'h2222, 2'b10);
        repeat (3) step();
        sample_tick = 1'b1;
        step();
        sample_tick = 1'b0;
        check16("hs_sample2", bus.sample, 16'h2222);
        check1("hs_overrun_set", overrun, 1'b1);
        step();
        check16("hs_sample_hold", bus.sample, 16'h2222);
        bus.sample_ready = 1'b1;
        step();
        check1("hs_valid_clear", bus.sample_valid, 1'b0);
        check1("hs_overrun_sticky", overrun, 1'b1);

        // Asynchronous reset mid-run
        enable      = 4'b1111;
        sample_tick = 1'b1;
        step();
        #2;
        rst = 1'b1;
        #1;
        check16("arst_sample", bus.sample, 16'h0000);
        check1("arst_valid", bus.sample_valid, 1'b0);
        check1("arst_overrun", overrun, 1'b0);
        sample_tick = 1'b0;
        step();
        rst = 1'b0;
        step();
        sample_tick = 1'b1;
        step();
        sample_tick = 1'b0;
        check16("post_reset_sample", bus.sample, 16'h0000);
        check1("post_reset_valid", bus.sample_valid, 1'b1);

        // Out-of-range channel select on the 3-channel instance
        enable3              = 3'b111;
        bus3.cfg_we          = 1'b1;
        bus3.cfg_ch          = 2'd3;
        bus3.cfg_half_period = 21'd1000;
        bus3.cfg_volume      = 16'h7777;
        bus3.cfg_mode        = 2'b10;
        step();
        bus3.cfg_we = 1'b0;
        step();
        tick3 = 1'b1;
        step();
        tick3 = 1'b0;
        check16("cfg_ch_out_of_range", bus3.sample, 16'h0000);
        bus3.cfg_we = 1'b1;
        bus3.cfg_ch = 2'd2;
        step();
        bus3.cfg_we = 1'b0;
        step();
        tick3 = 1'b1;
        step();
        tick3 = 1'b0;
        check16("cfg_ch_in_range", bus3.sample, 16'h7777);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global guard so the run always ends
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
`default_nettype wire
